// File: rtl/elev_call_dispatch_if.sv
// Call-dispatch bus between the button/controller side and the dispatcher.
// The master side drives the buttons and car status. The slave side (the
// dispatcher) returns the target, the pending mask and the busy flag.
interface elev_call_dispatch_if #(
  parameter int NFLOORS = 4
);
  localparam int FW = (NFLOORS > 1) ? $clog2(NFLOORS) : 1;

  logic [NFLOORS-1:0] call_btn;
  logic [FW-1:0]      cur_floor;
  logic               door_open;
  logic [NFLOORS-1:0] floor_btn;
  logic [NFLOORS-1:0] pending;
  logic               busy;

  modport master (
    output call_btn, cur_floor, door_open,
    input  floor_btn, pending, busy
  );

  modport slave (
    input  call_btn, cur_floor, door_open,
    output floor_btn, pending, busy
  );
endinterface

// File: rtl/elev_call_dispatch.sv
// Elevator call dispatcher.
// Latches button presses as pending requests and hands them out one at a time
// in SCAN (up/down sweep) order as a one-hot target word. A request is cleared
// when the car stands at that floor with the door open.
module elev_call_dispatch #(
  parameter int NFLOORS = 4,
  parameter int DWELL   = 2
) (
  input logic            clk,
  input logic            rst,
  elev_call_dispatch_if.slave bus
);
  localparam int FW    = (NFLOORS > 1) ? $clog2(NFLOORS) : 1;
  localparam int DCW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int DLAST = (DWELL > 0) ? DWELL - 1 : 0;

  typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DWELL} state_t;

  state_t             state_reg, state_next;
  logic [NFLOORS-1:0] btn_reg;
  logic [NFLOORS-1:0] pending_reg, pending_next;
  logic [NFLOORS-1:0] floor_btn_reg, floor_btn_next;
  logic [FW-1:0]      target_reg, target_next;
  logic [DCW-1:0]     dwell_cnt_reg, dwell_cnt_next;
  logic               dir_up_reg, dir_up_next;
  logic               busy_reg;

  logic [NFLOORS-1:0] new_call;
  logic [NFLOORS-1:0] cur_onehot;
  logic [NFLOORS-1:0] served;
  logic [NFLOORS-1:0] up_set;
  logic [NFLOORS-1:0] dn_set;
  logic [FW-1:0]      pick;

  // Lowest set bit index of v (0 when v is empty).
  function automatic logic [FW-1:0] lowest_idx(input logic [NFLOORS-1:0] v);
    lowest_idx = '0;
    for (int i = NFLOORS - 1; i >= 0; i--)
      if (v[i]) lowest_idx = FW'(i);
  endfunction

  // Highest set bit index of v (0 when v is empty).
  function automatic logic [FW-1:0] highest_idx(input logic [NFLOORS-1:0] v);
    highest_idx = '0;
    for (int i = 0; i < NFLOORS; i++)
      if (v[i]) highest_idx = FW'(i);
  endfunction

  // Per-floor decode of the car position. An out-of-range cur_floor matches
  // no bit, so it serves nothing and never equals a (always in-range) target.
  for (genvar gi = 0; gi < NFLOORS; gi++) begin : g_floor
    assign cur_onehot[gi] = (bus.cur_floor == FW'(gi));
    assign up_set[gi]     = pending_reg[gi] & (FW'(gi) > bus.cur_floor);
    assign dn_set[gi]     = pending_reg[gi] & (FW'(gi) < bus.cur_floor);
  end

  assign new_call     = bus.call_btn & ~btn_reg;
  assign served       = bus.door_open ? cur_onehot : '0;
  // Clearing wins over a same-cycle press at the open-door floor.
  assign pending_next = (pending_reg | new_call) & ~served;

  // Button history for edge detection; also loaded during reset so a button
  // held through reset does not register as a fresh press.
  always_ff @(posedge clk) begin
    btn_reg <= bus.call_btn;
  end

  // Dispatch FSM next-state: target selection in IDLE, arrival in MOVE,
  // hold timer in DWELL.
  always_comb begin
    state_next     = state_reg;
    floor_btn_next = floor_btn_reg;
    target_next    = target_reg;
    dwell_cnt_next = dwell_cnt_reg;
    dir_up_next    = dir_up_reg;
    pick           = '0;
    case (state_reg)
      ST_IDLE: begin
        floor_btn_next = '0;
        if (bus.door_open && ((up_set | dn_set) != '0)) begin
          if (dir_up_reg) begin
            if (up_set != '0) begin
              pick = lowest_idx(up_set);
            end else begin
              pick        = highest_idx(dn_set);
              dir_up_next = 1'b0;
            end
          end else begin
            if (dn_set != '0) begin
              pick = highest_idx(dn_set);
            end else begin
              pick        = lowest_idx(up_set);
              dir_up_next = 1'b1;
            end
          end
          target_next    = pick;
          floor_btn_next = NFLOORS'(1) << pick;
          state_next     = ST_MOVE;
        end
      end
      ST_MOVE: begin
        // Door still open at the departure floor is not an arrival.
        if (bus.door_open && (bus.cur_floor == target_reg)) begin
          if (DWELL == 0) begin
            state_next     = ST_IDLE;
            floor_btn_next = '0;
          end else begin
            state_next     = ST_DWELL;
            dwell_cnt_next = '0;
          end
        end
      end
      ST_DWELL: begin
        dwell_cnt_next = dwell_cnt_reg + 1'b1;
        if (dwell_cnt_reg == DCW'(DLAST)) begin
          state_next     = ST_IDLE;
          floor_btn_next = '0;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        floor_btn_next = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops all pending calls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pending_reg   <= '0;
      floor_btn_reg <= '0;
      target_reg    <= '0;
      dwell_cnt_reg <= '0;
      dir_up_reg    <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      floor_btn_reg <= floor_btn_next;
      target_reg    <= target_next;
      dwell_cnt_reg <= dwell_cnt_next;
      dir_up_reg    <= dir_up_next;
      busy_reg      <= (state_next != ST_IDLE);
    end
  end

  assign bus.floor_btn = floor_btn_reg;
  assign bus.pending   = pending_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_elev_call_dispatch.sv
// Directed bench for elev_call_dispatch (NFLOORS=4, DWELL=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_elev_call_dispatch;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  elev_call_dispatch_if #(.NFLOORS(4)) bus ();

  elev_call_dispatch #(.NFLOORS(4), .DWELL(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) begin
      $display("[TB] %s obs=%0h ok", tag, obs);
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] fb, input logic [3:0] pd,
                         input logic bz);
    chk({tag, ".floor_btn"}, 32'(bus.floor_btn), 32'(fb));
    chk({tag, ".pending"},   32'(bus.pending),   32'(pd));
    chk({tag, ".busy"},      32'(bus.busy),      32'(bz));
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.call_btn  = 4'b0010;
    bus.cur_floor = 2'd0;
    bus.door_open = 1'b0;

    // T1: button held through reset never becomes a call
    tick();
    tick();
    chk_out("t1_rst", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk_out("t1_held", 4'b0000, 4'b0000, 1'b0);
    bus.call_btn = 4'b0000;
    tick();

    // T2: dispatch from floor 0 to floor 3, latency and dwell
    bus.door_open = 1'b1;
    bus.call_btn  = 4'b1000;
    tick();
    chk_out("t2_latch", 4'b0000, 4'b1000, 1'b0);
    bus.call_btn = 4'b0000;
    tick();
    chk_out("t2_dispatch", 4'b1000, 4'b1000, 1'b1);
    bus.door_open = 1'b0;
    tick();
    chk("t2_move1.floor_btn", 32'(bus.floor_btn), 32'h8);
    tick();
    chk("t2_move2.floor_btn", 32'(bus.floor_btn), 32'h8);
    tick();
    chk("t2_move3.floor_btn", 32'(bus.floor_btn), 32'h8);
    bus.cur_floor = 2'd3;
    bus.door_open = 1'b1;
    tick();
    chk_out("t2_arrive", 4'b1000, 4'b0000, 1'b1);
    tick();
    chk_out("t2_dwell", 4'b1000, 4'b0000, 1'b1);
    tick();
    chk_out("t2_done", 4'b0000, 4'b0000, 1'b0);

    // T3: at floor 1 going up with pending 1001 -> 3 first, then reverse to 0
    bus.door_open = 1'b0;
    bus.cur_floor = 2'd1;
    bus.call_btn  = 4'b1001;
    tick();
    chk_out("t3_latch", 4'b0000, 4'b1001, 1'b0);
    bus.call_btn = 4'b0000;
    tick();
    chk_out("t3_closed", 4'b0000, 4'b1001, 1'b0);
    bus.door_open = 1'b1;
    tick();
    chk_out("t3_pick_up", 4'b1000, 4'b1001, 1'b1);
    bus.door_open = 1'b0;
    tick();
    bus.cur_floor = 2'd3;
    bus.door_open = 1'b1;
    tick();
    chk_out("t3_arrive3", 4'b1000, 4'b0001, 1'b1);
    tick();
    tick();
    chk_out("t3_dwell_end", 4'b0000, 4'b0001, 1'b0);
    tick();
    chk_out("t3_pick_down", 4'b0001, 4'b0001, 1'b1);
    bus.door_open = 1'b0;
    tick();
    bus.cur_floor = 2'd0;
    bus.door_open = 1'b1;
    tick();
    tick();
    tick();
    chk_out("t3_done", 4'b0000, 4'b0000, 1'b0);

    // T4: no retarget mid-trip; new call served after arrival
    bus.call_btn = 4'b0100;
    tick();
    bus.call_btn = 4'b0000;
    tick();
    chk_out("t4_pick2", 4'b0100, 4'b0100, 1'b1);
    bus.door_open = 1'b0;
    tick();
    bus.call_btn = 4'b1000;
    tick();
    chk_out("t4_press3", 4'b0100, 4'b1100, 1'b1);
    bus.call_btn = 4'b0000;
    tick();
    chk("t4_hold.floor_btn", 32'(bus.floor_btn), 32'h4);
    bus.cur_floor = 2'd2;
    bus.door_open = 1'b1;
    tick();
    chk_out("t4_arrive2", 4'b0100, 4'b1000, 1'b1);
    tick();
    tick();
    chk("t4_idle.floor_btn", 32'(bus.floor_btn), 32'h0);
    tick();
    chk_out("t4_pick3", 4'b1000, 4'b1000, 1'b1);
    bus.door_open = 1'b0;
    tick();
    bus.cur_floor = 2'd3;
    bus.door_open = 1'b1;
    tick();
    tick();
    tick();
    chk_out("t4_done", 4'b0000, 4'b0000, 1'b0);

    // T5: press at the open-door floor is never latched
    bus.cur_floor = 2'd2;
    bus.call_btn  = 4'b0100;
    tick();
    chk("t5_same_floor.pending", 32'(bus.pending), 32'h0);
    bus.call_btn = 4'b0000;
    tick();
    chk_out("t5_no_dispatch", 4'b0000, 4'b0000, 1'b0);
    // T5b: press on the arrival cycle at floor 2 is cleared
    bus.door_open = 1'b0;
    bus.cur_floor = 2'd3;
    bus.call_btn  = 4'b0100;
    tick();
    bus.call_btn  = 4'b0000;
    bus.door_open = 1'b1;
    tick();
    chk_out("t5_pick2", 4'b0100, 4'b0100, 1'b1);
    bus.door_open = 1'b0;
    tick();
    bus.cur_floor = 2'd2;
    bus.door_open = 1'b1;
    bus.call_btn  = 4'b0100;
    tick();
    chk_out("t5_arrive_press", 4'b0100, 4'b0000, 1'b1);
    bus.call_btn = 4'b0000;
    tick();
    tick();
    tick();
    chk_out("t5_done", 4'b0000, 4'b0000, 1'b0);

    // T6: reset in the middle of a move drops everything
    bus.cur_floor = 2'd0;
    bus.call_btn  = 4'b1010;
    tick();
    bus.call_btn = 4'b0000;
    tick();
    chk_out("t6_move", 4'b0010, 4'b1010, 1'b1);
    rst = 1'b1;
    tick();
    chk_out("t6_rst", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    chk_out("t6_after", 4'b0000, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
